// File: rtl/redmule_x_sched_pkg.sv
// Shared types for the X operand buffer sequencer: FSM states, job configuration and
// the X buffer control/flag buses.
package redmule_x_sched_pkg;

  localparam int unsigned ARRAY_HEIGHT = 4;
  localparam int unsigned ARRAY_WIDTH  = 4;
  localparam int unsigned TOT_DEPTH    = 8;
  localparam int unsigned CNT_W        = 16;

  localparam int unsigned WIDTH_W  = $clog2(ARRAY_WIDTH) + 1;
  localparam int unsigned HEIGHT_W = $clog2(ARRAY_HEIGHT) + 1;
  localparam int unsigned SLOTS_W  = $clog2(TOT_DEPTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    RUN,
    DONE
  } x_sched_state_e;

  typedef struct packed {
    logic [CNT_W-1:0]    tiles;
    logic [CNT_W-1:0]    shifts;
    logic [WIDTH_W-1:0]  width;
    logic [HEIGHT_W-1:0] height;
    logic [SLOTS_W-1:0]  slots;
  } x_sched_cfg_t;

  typedef struct packed {
    logic full;
    logic empty;
  } x_buffer_flgs_t;

  typedef struct packed {
    logic [WIDTH_W-1:0]  width;
    logic [HEIGHT_W-1:0] height;
    logic [SLOTS_W-1:0]  slots;
    logic                load;
    logic                pad_setup;
    logic                rst_w_index;
    logic                h_shift;
    logic                last_x;
  } x_buffer_ctrl_t;

endpackage

// File: rtl/redmule_x_sched_cnt.sv
// Saturating up-counter with synchronous clear, enable and a terminal-count compare
// against a run-time limit.
module redmule_x_sched_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [Width-1:0] last_i,
  output logic [Width-1:0] cnt_o,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == last_i);

endmodule

// File: rtl/redmule_x_sched.sv
// X operand buffer sequencer: loads tiles from the streamer, paces array shifts and
// stalls at tile boundaries. Define REDMULE_X_SCHED_PERF_EN to add stall/shift counters.
module redmule_x_sched
  import redmule_x_sched_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clear_i,
  input  logic           start_i,
  input  x_sched_cfg_t   cfg_i,
  input  logic           x_valid_i,
  output logic           x_ready_o,
  input  logic           shift_req_i,
  output logic           stall_o,
  input  x_buffer_flgs_t flags_i,
  output x_buffer_ctrl_t ctrl_o,
  output logic           busy_o,
  output logic           done_o
`ifdef REDMULE_X_SCHED_PERF_EN
  ,
  output logic [31:0]    perf_stall_o,
  output logic [31:0]    perf_shift_o
`endif
);

  x_sched_state_e state_q;
  x_sched_cfg_t   cfg_q;
  logic           full_q;

  logic [CNT_W-1:0] loaded_cnt, used_cnt, shift_cnt;
  logic             loaded_tc, used_tc, shift_tc;
  logic             job_clr, loaded_en, boundary_shift, used_more;
  logic             h_shift, stall;
  logic             unused_sig;

  assign job_clr = clear_i || ((state_q == IDLE) && start_i);

  // A boundary shift consumes the last column of the current tile.
  assign boundary_shift = h_shift && shift_tc;
  assign used_more = (({1'b0, used_cnt} + (CNT_W + 1)'(1)) < {1'b0, cfg_q.tiles});
  assign loaded_en = ((state_q == LOAD) && flags_i.full) ||
                     ((state_q == RUN) && flags_i.full && !full_q);

  redmule_x_sched_cnt #(.Width(CNT_W)) i_loaded_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (job_clr),
    .en_i    (loaded_en),
    .last_i  (cfg_q.tiles),
    .cnt_o   (loaded_cnt),
    .tc_o    (loaded_tc)
  );

  redmule_x_sched_cnt #(.Width(CNT_W)) i_used_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (job_clr),
    .en_i    (boundary_shift),
    .last_i  (cfg_q.tiles - CNT_W'(1)),
    .cnt_o   (used_cnt),
    .tc_o    (used_tc)
  );

  redmule_x_sched_cnt #(.Width(CNT_W)) i_shift_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (job_clr || boundary_shift),
    .en_i    (h_shift),
    .last_i  (cfg_q.shifts - CNT_W'(1)),
    .cnt_o   (shift_cnt),
    .tc_o    (shift_tc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      full_q  <= 1'b0;
    end else if (clear_i) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      full_q <= flags_i.full;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            cfg_q   <= cfg_i;
            state_q <= (cfg_i.tiles == '0) ? DONE : LOAD;
          end
        end
        LOAD:    if (flags_i.full) state_q <= SETUP;
        SETUP:   state_q <= RUN;
        RUN:     if (boundary_shift && used_tc) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall and h_shift deliberately ignore flags_i.empty: empty is itself driven by h_shift.
  always_comb begin
    ctrl_o        = '0;
    ctrl_o.width  = cfg_q.width;
    ctrl_o.height = cfg_q.height;
    ctrl_o.slots  = cfg_q.slots;
    x_ready_o     = 1'b0;
    stall         = 1'b0;
    h_shift       = 1'b0;
    unique case (state_q)
      LOAD: begin
        x_ready_o   = ~flags_i.full;
        ctrl_o.load = x_valid_i && x_ready_o;
      end
      SETUP: begin
        ctrl_o.pad_setup   = 1'b1;
        ctrl_o.rst_w_index = 1'b1;
      end
      RUN: begin
        x_ready_o          = ~flags_i.full && (loaded_cnt < cfg_q.tiles);
        ctrl_o.load        = x_valid_i && x_ready_o;
        stall              = shift_req_i && shift_tc && used_more && ~flags_i.full;
        h_shift            = shift_req_i && ~stall;
        ctrl_o.h_shift     = h_shift;
        ctrl_o.rst_w_index = h_shift && shift_tc && used_more;
        ctrl_o.last_x      = used_tc;
      end
      default: ;
    endcase
  end

  assign stall_o = stall;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);

  assign unused_sig = ^{loaded_tc, shift_cnt, flags_i.empty};

`ifdef REDMULE_X_SCHED_PERF_EN
  logic [31:0] perf_stall_q, perf_shift_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_q <= '0;
      perf_shift_q <= '0;
    end else if (job_clr) begin
      perf_stall_q <= '0;
      perf_shift_q <= '0;
    end else begin
      if (stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      if (h_shift && (perf_shift_q != '1)) perf_shift_q <= perf_shift_q + 32'd1;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_shift_o = perf_shift_q;
`endif

`ifndef SYNTHESIS
  a_boundary_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    boundary_shift |-> flags_i.empty);
`endif

endmodule

// File: tb/tb_redmule_x_sched.sv
// Directed bench for redmule_x_sched with a behavioural X buffer and streamer model.
module tb_redmule_x_sched;
  import redmule_x_sched_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_ni, clear_i, start_i, x_valid_i, x_ready_o;
  logic           shift_req_i, stall_o, busy_o, done_o;
  x_sched_cfg_t   cfg_i;
  x_buffer_flgs_t flags_i;
  x_buffer_ctrl_t ctrl_o;
`ifdef REDMULE_X_SCHED_PERF_EN
  logic [31:0]    perf_stall_o, perf_shift_o;
`endif

  redmule_x_sched dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .cfg_i       (cfg_i),
    .x_valid_i   (x_valid_i),
    .x_ready_o   (x_ready_o),
    .shift_req_i (shift_req_i),
    .stall_o     (stall_o),
    .flags_i     (flags_i),
    .ctrl_o      (ctrl_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef REDMULE_X_SCHED_PERF_EN
    ,
    .perf_stall_o (perf_stall_o),
    .perf_shift_o (perf_shift_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Behavioural X buffer: full after ARRAY_WIDTH loads, released by rst_w_index;
  // empty flags the last column of a tile as it is shifted out.
  logic        buf_full, empty_c, drip, stream_en, drip_v;
  int unsigned buf_rows, sh_in_tile, cur_shifts, drip_t;

  assign empty_c   = ctrl_o.h_shift && (sh_in_tile == cur_shifts - 1);
  assign flags_i   = {buf_full, empty_c};
  assign x_valid_i = stream_en && (drip ? drip_v : 1'b1);

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || clear_i) begin
      buf_full   <= 1'b0;
      buf_rows   <= 0;
      sh_in_tile <= 0;
    end else begin
      if (ctrl_o.rst_w_index && buf_full) begin
        buf_full <= 1'b0;
        buf_rows <= 0;
      end else if (ctrl_o.load) begin
        if (buf_rows + 1 == ARRAY_WIDTH) buf_full <= 1'b1;
        buf_rows <= buf_rows + 1;
      end
      if (ctrl_o.h_shift) sh_in_tile <= (sh_in_tile == cur_shifts - 1) ? 0 : sh_in_tile + 1;
    end
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || clear_i) begin
      drip_v <= 1'b0;
      drip_t <= 0;
    end else if (drip_v) begin
      if (x_valid_i && x_ready_o) begin
        drip_v <= 1'b0;
        drip_t <= 0;
      end
    end else if (drip_t == 9) begin
      drip_v <= 1'b1;
    end else begin
      drip_t <= drip_t + 1;
    end
  end

  typedef struct {
    int unsigned tiles;
    int unsigned shifts;
    bit          drip;
    bit          poke;
    int unsigned e_hs;
    int unsigned e_ld;
    int unsigned e_lx;
    int unsigned e_rw;
    int unsigned e_rw_at;
    bit          e_stall;
  } vec_t;

  vec_t        vecs[4];
  int unsigned n_pass, n_total;
  int unsigned n_hs, n_st, n_ld, n_dn, n_lx, n_rw, n_xr, rw_at;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clr_mon();
    n_hs = 0; n_st = 0; n_ld = 0; n_dn = 0; n_lx = 0; n_rw = 0; n_xr = 0; rw_at = 0;
  endtask

  // One clock cycle: sample outputs mid-cycle, then return 1 time unit after the edge.
  task automatic step();
    @(negedge clk_i);
    if (ctrl_o.h_shift) n_hs++;
    if (stall_o) n_st++;
    if (ctrl_o.load) n_ld++;
    if (done_o) n_dn++;
    if (ctrl_o.last_x) n_lx++;
    if (ctrl_o.rst_w_index) n_rw++;
    if (x_ready_o) n_xr++;
    if (ctrl_o.rst_w_index && ctrl_o.h_shift && rw_at == 0) rw_at = n_hs;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cfg(input int unsigned tiles, input int unsigned shifts);
    cfg_i.tiles  = CNT_W'(tiles);
    cfg_i.shifts = CNT_W'(shifts);
    cfg_i.width  = WIDTH_W'(ARRAY_WIDTH);
    cfg_i.height = HEIGHT_W'(ARRAY_HEIGHT);
    cfg_i.slots  = SLOTS_W'(TOT_DEPTH);
    cur_shifts   = shifts;
  endtask

  task automatic run_job(input vec_t v);
    clr_mon();
    set_cfg(v.tiles, v.shifts);
    drip        = v.drip;
    stream_en   = 1'b1;
    shift_req_i = 1'b1;
    start_i     = 1'b1;
    step();
    for (int c = 0; c < 3000 && n_dn == 0; c++) begin
      start_i     = v.poke && (c == 1);
      cfg_i.tiles = start_i ? '0 : CNT_W'(v.tiles);
      step();
    end
    start_i = 1'b0;
    step();
    step();
    shift_req_i = 1'b0;
    stream_en   = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    clr_mon();
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    shift_req_i = 1'b1; stream_en = 1'b1; drip = 1'b0;
    set_cfg(1, 4);

    vecs[0] = '{tiles: 1, shifts: 4, drip: 0, poke: 1, e_hs: 4,  e_ld: 4,  e_lx: 4, e_rw: 1, e_rw_at: 0, e_stall: 0};
    vecs[1] = '{tiles: 3, shifts: 8, drip: 1, poke: 0, e_hs: 24, e_ld: 12, e_lx: 8, e_rw: 3, e_rw_at: 8, e_stall: 1};
    vecs[2] = '{tiles: 2, shifts: 8, drip: 0, poke: 0, e_hs: 16, e_ld: 8,  e_lx: 8, e_rw: 2, e_rw_at: 8, e_stall: 0};
    vecs[3] = '{tiles: 0, shifts: 4, drip: 0, poke: 0, e_hs: 0,  e_ld: 0,  e_lx: 0, e_rw: 0, e_rw_at: 0, e_stall: 0};

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_x_ready", 32'(x_ready_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_ctrl", 32'(ctrl_o), 0);
    rst_ni = 1'b1;
    shift_req_i = 1'b0;
    stream_en = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_job(vecs[i]);
      chk($sformatf("v%0d_h_shift", i), n_hs, vecs[i].e_hs);
      chk($sformatf("v%0d_loads", i), n_ld, vecs[i].e_ld);
      chk($sformatf("v%0d_done_pulses", i), n_dn, 1);
      chk($sformatf("v%0d_last_x_cycles", i), n_lx, vecs[i].e_lx);
      chk($sformatf("v%0d_rst_w_index", i), n_rw, vecs[i].e_rw);
      chk($sformatf("v%0d_rst_w_at_shift", i), rw_at, vecs[i].e_rw_at);
      chk($sformatf("v%0d_stalled", i), 32'(n_st != 0), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_busy_after", i), 32'(busy_o), 0);
`ifdef REDMULE_X_SCHED_PERF_EN
      chk($sformatf("v%0d_perf_shift", i), perf_shift_o, vecs[i].e_hs);
      chk($sformatf("v%0d_perf_stall", i), perf_stall_o, n_st);
`endif
    end

    // tiles==0: done_o exactly one cycle after start, no load handshake.
    clr_mon();
    set_cfg(0, 4);
    stream_en = 1'b1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("t0_done_next", 32'(done_o), 1);
    chk("t0_busy_next", 32'(busy_o), 1);
    step();
    chk("t0_done_after", 32'(done_o), 0);
    chk("t0_busy_after", 32'(busy_o), 0);
    chk("t0_x_ready_cycles", n_xr, 0);
    stream_en = 1'b0;

    // clear_i in RUN after 3 shifts, then a clean restart.
    clr_mon();
    set_cfg(2, 8);
    drip = 1'b0;
    stream_en = 1'b1;
    shift_req_i = 1'b1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int c = 0; c < 500 && n_hs < 3; c++) step();
    clear_i = 1'b1;
    shift_req_i = 1'b0;
    step();
    clear_i = 1'b0;
    chk("clr_busy", 32'(busy_o), 0);
    chk("clr_ctrl", 32'(ctrl_o), 0);
    chk("clr_x_ready", 32'(x_ready_o), 0);
    chk("clr_stall", 32'(stall_o), 0);
    chk("clr_shifts_before", n_hs, 3);
    step();
    chk("clr_no_done", n_dn, 0);
    stream_en = 1'b0;

    run_job('{tiles: 1, shifts: 4, drip: 0, poke: 0, e_hs: 4, e_ld: 4, e_lx: 4, e_rw: 1, e_rw_at: 0, e_stall: 0});
    chk("restart_h_shift", n_hs, 4);
    chk("restart_loads", n_ld, 4);
    chk("restart_done", n_dn, 1);
    chk("restart_last_x", n_lx, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
